// File: rtl/intr_ctrl_if.sv
// Interrupt controller bus: request lines, mask/overflow control, and the
// presented-interrupt handshake. The controller uses the slave modport.
interface intr_ctrl_if #(
  parameter int NUM_CH = 8
);
  localparam int ID_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] irq_req;
  logic              int_en;
  logic              mask_wr;
  logic [NUM_CH-1:0] mask_in;
  logic              ovf_clr;
  logic              irq_ack;
  logic              irq_valid;
  logic [ID_W-1:0]   irq_id;
  logic [NUM_CH-1:0] mask_out;
  logic [NUM_CH-1:0] pending_out;
  logic [7:0]        status;

  modport master (
    output irq_req, int_en, mask_wr, mask_in, ovf_clr, irq_ack,
    input  irq_valid, irq_id, mask_out, pending_out, status
  );

  modport slave (
    input  irq_req, int_en, mask_wr, mask_in, ovf_clr, irq_ack,
    output irq_valid, irq_id, mask_out, pending_out, status
  );
endinterface

// File: rtl/intr_ctrl.sv
// Priority interrupt controller: pending/mask registers, highest-index-wins
// arbitration, IDLE/PRESENT handshake. Define INTR_CTRL_EDGE_DETECT_EN for
// edge-triggered requests with overflow tracking; default is level-sensitive.
module intr_ctrl #(
  parameter int NUM_CH = 8
) (
  input  logic        clk,
  input  logic        rst,
  intr_ctrl_if.slave  bus
);
  localparam int ID_W = $clog2(NUM_CH);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t            state, state_n;
  logic [NUM_CH-1:0] pending, pending_n, mask, active, set_v, clr_v;
  logic [ID_W-1:0]   irq_id, irq_id_n, win_id;
  logic              ovf;
  logic [4:0]        cnt;
  logic [3:0]        pend_cnt;
  logic [7:0]        status;

  assign active = pending & ~mask;

  always_comb begin
    clr_v = '0;
    if (state == PRESENT && bus.irq_ack) clr_v[irq_id] = 1'b1;
  end

`ifdef INTR_CTRL_EDGE_DETECT_EN
  logic [NUM_CH-1:0] req_q;

  // History clears on reset, so a line already high afterwards counts as a rise.
  always_ff @(posedge clk) begin
    if (rst) req_q <= '0;
    else     req_q <= bus.irq_req;
  end

  assign set_v = bus.irq_req & ~req_q;

  always_ff @(posedge clk) begin
    if (rst)                              ovf <= 1'b0;
    else if (|(set_v & pending & ~clr_v)) ovf <= 1'b1;
    else if (bus.ovf_clr)                 ovf <= 1'b0;
  end
`else
  assign set_v = bus.irq_req;
  assign ovf   = 1'b0;
`endif

  // Set is applied after clear so a simultaneous new request keeps the bit.
  assign pending_n = (pending & ~clr_v) | set_v;

  always_comb begin
    win_id = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (active[i]) win_id = ID_W'(i);
  end

  always_comb begin
    state_n  = state;
    irq_id_n = irq_id;
    case (state)
      IDLE:
        if (bus.int_en && |active) begin
          state_n  = PRESENT;
          irq_id_n = win_id;
        end
      PRESENT:
        if (bus.irq_ack) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_CH; i++) cnt = cnt + 5'(pending[i]);
    pend_cnt = (cnt > 5'd15) ? 4'hF : cnt[3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      irq_id  <= '0;
      pending <= '0;
      mask    <= '1;
      status  <= '0;
    end else begin
      state   <= state_n;
      irq_id  <= irq_id_n;
      pending <= pending_n;
      if (bus.mask_wr) mask <= bus.mask_in;
      status  <= {bus.int_en, state == PRESENT, |active, ovf, pend_cnt};
    end
  end

  assign bus.irq_valid   = (state == PRESENT);
  assign bus.irq_id      = irq_id;
  assign bus.mask_out    = mask;
  assign bus.pending_out = pending;
  assign bus.status      = status;
endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl (NUM_CH=8): priority, masking, overflow,
// set/clear collision and reset behaviour, in either request mode.
module tb_intr_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   failed = 0;

`ifdef INTR_CTRL_EDGE_DETECT_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  intr_ctrl_if #(.NUM_CH(8)) bus ();
  intr_ctrl #(.NUM_CH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ack();
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.irq_req = '0; bus.int_en = 1'b0; bus.mask_wr = 1'b0;
    bus.mask_in = '0; bus.ovf_clr = 1'b0; bus.irq_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_valid", bus.irq_valid, 0);
    check("rst_id", bus.irq_id, 0);
    check("rst_mask", bus.mask_out, 8'hFF);
    check("rst_pend", bus.pending_out, 0);
    check("rst_status", bus.status, 0);

    // Priority: two channels, higher index first.
    bus.mask_wr = 1'b1; bus.mask_in = 8'h00;
    tick();
    bus.mask_wr = 1'b0;
    check("mask_wr0", bus.mask_out, 8'h00);
    bus.int_en = 1'b1;
    bus.irq_req = 8'h24;
    tick();
    bus.irq_req = 8'h00;
    check("pri_pend", bus.pending_out, 8'h24);
    check("pri_nvalid", bus.irq_valid, 0);
    tick();
    check("pri_valid", bus.irq_valid, 1);
    check("pri_id5", bus.irq_id, 5);
    check("pri_stat1", bus.status, 8'hA2);
    tick();
    check("pri_hold", bus.irq_id, 5);
    check("pri_stat2", bus.status, 8'hE2);
    ack();
    check("pri_ack_valid", bus.irq_valid, 0);
    check("pri_ack_pend", bus.pending_out, 8'h04);
    tick();
    check("pri_valid2", bus.irq_valid, 1);
    check("pri_id2", bus.irq_id, 2);
    ack();
    check("pri_clr", bus.pending_out, 8'h00);
    tick();
    check("pri_idle", bus.irq_valid, 0);

    // Masking: masked channel stays pending, unmask presents it.
    bus.mask_wr = 1'b1; bus.mask_in = 8'h80;
    tick();
    bus.mask_wr = 1'b0;
    bus.irq_req = 8'h80;
    tick();
    bus.irq_req = 8'h00;
    tick(); tick();
    check("msk_nvalid", bus.irq_valid, 0);
    check("msk_pend", bus.pending_out, 8'h80);
    bus.mask_wr = 1'b1; bus.mask_in = 8'h00;
    tick();
    bus.mask_wr = 1'b0;
    check("msk_late", bus.irq_valid, 0);
    tick();
    check("msk_valid", bus.irq_valid, 1);
    check("msk_id7", bus.irq_id, 7);
    // Presented ID must survive int_en drop, mask change and new requests.
    bus.int_en = 1'b0; bus.mask_wr = 1'b1; bus.mask_in = 8'hFF; bus.irq_req = 8'h01;
    tick();
    bus.mask_wr = 1'b0; bus.irq_req = 8'h00;
    tick();
    check("msk_hold_v", bus.irq_valid, 1);
    check("msk_hold_id", bus.irq_id, 7);
    ack();
    check("msk_ack_pend", bus.pending_out, 8'h01);
    tick();
    check("msk_en_off", bus.irq_valid, 0);
    bus.int_en = 1'b1; bus.mask_wr = 1'b1; bus.mask_in = 8'h00;
    tick();
    bus.mask_wr = 1'b0;
    tick();
    check("msk_ch0_id", bus.irq_id, 0);
    check("msk_ch0_v", bus.irq_valid, 1);
    ack();

    // Overflow: second request on a still-pending channel.
    bus.irq_req = 8'h08;
    tick();
    bus.irq_req = 8'h00;
    tick();
    bus.irq_req = 8'h08;
    tick();
    bus.irq_req = 8'h00;
    tick();
    check("ovf_set", bus.status[4], EDGE);
    check("ovf_id3", bus.irq_id, 3);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    tick();
    check("ovf_clr", bus.status[4], 0);
    ack();
    check("ovf_ack_pend", bus.pending_out, 8'h00);

    // Set/clear collision on the presented channel.
    bus.irq_req = 8'h02;
    tick();
    bus.irq_req = 8'h00;
    tick();
    check("col_id1", bus.irq_id, 1);
    bus.irq_ack = 1'b1; bus.irq_req = 8'h02;
    tick();
    bus.irq_ack = 1'b0; bus.irq_req = 8'h00;
    check("col_pend", bus.pending_out, 8'h02);
    check("col_idle", bus.irq_valid, 0);
    tick();
    check("col_valid", bus.irq_valid, 1);
    check("col_id_again", bus.irq_id, 1);
    check("col_ovf", bus.status[4], 0);
    ack();

    // Reset during PRESENT beats ack and mask write; held request is a rise.
    bus.irq_req = 8'h10;
    tick();
    bus.irq_req = 8'h00;
    tick();
    check("rr_id4", bus.irq_id, 4);
    rst = 1'b1; bus.irq_ack = 1'b1; bus.mask_wr = 1'b1; bus.mask_in = 8'h0F;
    bus.irq_req = 8'h01;
    tick();
    rst = 1'b0; bus.irq_ack = 1'b0; bus.mask_wr = 1'b0;
    check("rr_valid", bus.irq_valid, 0);
    check("rr_pend", bus.pending_out, 8'h00);
    check("rr_mask", bus.mask_out, 8'hFF);
    check("rr_status", bus.status, 8'h00);
    check("rr_id", bus.irq_id, 0);
    tick();
    bus.irq_req = 8'h00;
    check("rr_first_rise", bus.pending_out, 8'h01);
    tick();
    check("rr_masked", bus.irq_valid, 0);
    check("rr_cnt", bus.status, 8'h81);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
